dma_ib_fifo: RTL and testbench

Host-side input buffer that feeds the DDR write DMA engine. It accepts 16-bit host pipe words, packs pairs into 32-bit words (first half = low half), and stores them in a single-clock block-RAM FIFO. It presents the `ib_` read interface the DMA consumes: read enable, one-cycle-latency data with a valid strobe, a 10-bit fill count and an empty flag. The DMA starts a 32-word burst only when `ib_count >= 32`, so the count must be exact.

---
 rtl/dma_ib_fifo.sv | 107 ++++++++++
 tb/tb_dma_ib_fifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/dma_ib_fifo.sv
// Host input buffer for the DDR write DMA: packs 16-bit host halves into 32-bit words in a block-RAM FIFO.
// Read data arrives one cycle after an accepted ib_re; a word completed while full is dropped and flagged sticky.
module dma_ib_fifo #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          pi_we,
  input  logic [15:0]   pi_data,
  output logic          pi_full,
  output logic          overflow,
  input  logic          ib_re,
  output logic [31:0]   ib_data,
  output logic          ib_valid,
  output logic [AW-1:0] ib_count,
  output logic          ib_empty
);

  localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH - 1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic          half_pend_q, overflow_q, valid_q, empty_q, full_q;
  logic [15:0]   lo_q;
  logic [31:0]   data_q;
  logic          clr, wr_fire, wr_acc, rd_acc;
  logic [31:0]   wr_word;

  // Full/empty decisions use the count from before this edge, so a read at
  // count 0 is refused even when a write lands in the same cycle.
  always_comb begin
    clr     = reset || flush;
    wr_fire = pi_we && half_pend_q && !clr;
    wr_acc  = wr_fire && (count_q != FULL_CNT);
    rd_acc  = ib_re && (count_q != '0) && !clr;
    wr_word = {pi_data, lo_q};
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  // Output register doubles as the RAM read register; flush keeps the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q <= '0;
    end else if (pi_we && !half_pend_q && !flush) begin
      lo_q <= pi_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      half_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      if (pi_we) begin
        half_pend_q <= !half_pend_q;
      end
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (wr_fire && !wr_acc) begin
        overflow_q <= 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      valid_q <= rd_acc;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
    end
  end

  assign ib_data  = data_q;
  assign ib_valid = valid_q;
  assign ib_count = count_q;
  assign ib_empty = empty_q;
  assign pi_full  = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_dma_ib_fifo.sv
// Scoreboarded bench for dma_ib_fifo against a queue-based reference model.
module tb_dma_ib_fifo;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1, flush = 1'b0, pi_we = 1'b0, ib_re = 1'b0;
  logic [15:0] pi_data = '0;
  logic        pi_full, overflow, ib_valid, ib_empty;
  logic [31:0] ib_data;
  logic [9:0]  ib_count;

  always #5 clk = ~clk;

  dma_ib_fifo #(.DEPTH(DEPTH), .AW(10)) dut (
    .clk(clk), .reset(reset), .flush(flush), .pi_we(pi_we), .pi_data(pi_data),
    .pi_full(pi_full), .overflow(overflow), .ib_re(ib_re), .ib_data(ib_data),
    .ib_valid(ib_valid), .ib_count(ib_count), .ib_empty(ib_empty)
  );

  // Reference model: stored words, pending half, sticky overflow, last read word.
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  bit          m_pend, m_ovf, m_vld;
  logic [15:0] m_lo;
  logic [31:0] m_last;
  int          tests = 0, fails = 0;
  bit          chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && ib_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_data: unexpected ib_valid with data %h at %0t", ib_data, $time);
      end else begin
        check("rd_data", ib_data, exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit rst, input bit fl, input bit we, input logic [15:0] d, input bit re);
    int n0;
    @(negedge clk);
    if (chk_en) begin
      check("ib_count", 32'(ib_count), 32'(mq.size()));
      check("ib_empty", 32'(ib_empty), 32'(mq.size() == 0));
      check("pi_full",  32'(pi_full),  32'(mq.size() == DEPTH - 1));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("ib_valid", 32'(ib_valid), 32'(m_vld));
      check("ib_data_hold", ib_data, m_last);
    end
    reset = rst; flush = fl; pi_we = we; pi_data = d; ib_re = re;
    @(posedge clk);
    m_vld = 0;
    if (rst) begin
      mq.delete(); m_pend = 0; m_lo = '0; m_ovf = 0; m_last = '0;
    end else if (fl) begin
      mq.delete(); m_pend = 0; m_ovf = 0;
    end else begin
      n0 = mq.size();
      if (re && n0 != 0) begin
        m_last = mq.pop_front();
        exp_q.push_back(m_last);
        m_vld = 1;
      end
      if (we) begin
        if (!m_pend) begin
          m_lo = d; m_pend = 1;
        end else begin
          m_pend = 0;
          if (n0 == DEPTH - 1) m_ovf = 1;
          else mq.push_back({d, m_lo});
        end
      end
    end
  endtask

  task automatic half(input logic [15:0] d); step(0, 0, 1, d, 0); endtask
  task automatic rd();                       step(0, 0, 0, '0, 1); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0); endtask

  initial begin
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    chk_en = 1;
    idle(1);
    check("rst_count", 32'(ib_count), 32'd0);
    check("rst_empty", 32'(ib_empty), 32'd1);
    check("rst_data",  ib_data, 32'd0);
    rd(); rd(); rd(); idle(2);

    half(16'h1111); half(16'h2222); half(16'h3333); half(16'h4444);
    idle(1);
    check("pack_count", 32'(ib_count), 32'd2);
    rd(); rd(); idle(2);
    check("pack_word2", ib_data, 32'h44443333);

    for (int i = 0; i < 64; i++) half(16'(i));
    idle(1);
    check("burst_count", 32'(ib_count), 32'd32);
    for (int i = 0; i < 32; i++) rd();
    idle(2);
    check("burst_last", ib_data, {16'd63, 16'd62});

    for (int i = 0; i < 2046; i++) half(16'($urandom));
    idle(1);
    check("full_count", 32'(ib_count), 32'd1023);
    check("full_flag",  32'(pi_full), 32'd1);
    check("full_noovf", 32'(overflow), 32'd0);
    half(16'hDEAD); half(16'hBEEF); idle(1);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(ib_count), 32'd1023);
    for (int i = 0; i < 1023; i++) rd();
    idle(2);
    check("drain_empty", 32'(ib_empty), 32'd1);

    for (int i = 0; i < 20; i++) half(16'($urandom));
    half(16'h0A0A);
    step(0, 0, 1, 16'hB0B0, 1);
    idle(1);
    check("simul_count", 32'(ib_count), 32'd10);

    step(0, 1, 0, '0, 0);
    for (int i = 0; i < 10; i++) half(16'($urandom));
    half(16'h5555);
    step(0, 1, 0, '0, 0);
    idle(1);
    check("flush_count", 32'(ib_count), 32'd0);
    check("flush_empty", 32'(ib_empty), 32'd1);
    half(16'hAAAA); half(16'hBBBB); rd(); idle(2);
    check("flush_word", ib_data, 32'hBBBBAAAA);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(999) == 0), ($urandom_range(255) == 0),
           ($urandom_range(9) < 6), 16'($urandom), ($urandom_range(9) < 4));
    end
    idle(3);
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
